// File: rtl/md5_step_engine.sv
// md5_step_engine: MD5 compression of one 512-bit block, one step per clock.
// Latency: start sampled at E0, steps at E1..E64, final add at E65, done in the following cycle.
// Backpressure: none; start is ignored while busy and nothing is queued.
//
// Ports:
//   clk, rst_n         rising-edge clock, synchronous active-low reset
//   start              begin hashing msg_in with chain_in (accepted only when idle)
//   msg_in, chain_in   block words M[0..15] and chaining value A..D (latched on start)
//   s_addr / s_data    step index out, rotation amount back (bits [4:0] only)
//   k_addr / k_data    step index out, additive constant back
//   busy, done         run in progress / one-cycle completion pulse
//   digest_out         chain_in + final a..d, held until the next done or reset
module md5_step_engine (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [511:0] msg_in,
  input  logic [127:0] chain_in,
  output logic [5:0]   s_addr,
  input  logic [31:0]  s_data,
  output logic [5:0]   k_addr,
  input  logic [31:0]  k_data,
  output logic         busy,
  output logic         done,
  output logic [127:0] digest_out
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_ADD  = 2'd2;

  logic [1:0]   state_q, state_d;
  logic [5:0]   cnt_q, cnt_d;
  logic [31:0]  a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d;
  logic [511:0] msg_q, msg_d;
  logic [127:0] chain_q, chain_d;
  logic [127:0] digest_q, digest_d;
  logic         done_q, done_d;

  // Step datapath signals
  logic [3:0]   i4;
  logic [3:0]   g;
  logic [31:0]  f;
  logic [31:0]  m_word;
  logic [31:0]  tmp;
  logic [63:0]  rot_dbl;
  logic [31:0]  rot;

  // Only the low five bits of the shift table are meaningful.
  logic         unused_s_hi;
  assign unused_s_hi = ^s_data[31:5];

  assign s_addr     = cnt_q;
  assign k_addr     = cnt_q;
  assign busy       = (state_q == ST_RUN) || (state_q == ST_ADD);
  assign done       = done_q;
  assign digest_out = digest_q;

  // Round function and message word index. The g multiplies only need
  // i mod 16, so they are done in 4-bit arithmetic and wrap naturally.
  always_comb begin
    i4 = cnt_q[3:0];
    f  = '0;
    g  = '0;
    case (cnt_q[5:4])
      2'd0: begin
        f = (b_q & c_q) | (~b_q & d_q);
        g = i4;
      end
      2'd1: begin
        f = (d_q & b_q) | (~d_q & c_q);
        g = i4 + {i4[1:0], 2'b00} + 4'd1;   // 5i + 1
      end
      2'd2: begin
        f = b_q ^ c_q ^ d_q;
        g = i4 + {i4[2:0], 1'b0} + 4'd5;    // 3i + 5
      end
      default: begin
        f = c_q ^ (b_q | ~d_q);
        g = {i4[0], 3'b000} - i4;           // 8i - i
      end
    endcase
    m_word  = msg_q[{g, 5'b00000} +: 32];
    tmp     = a_q + f + k_data + m_word;
    // Rotate by shifting a doubled word; amount 0 leaves tmp unchanged.
    rot_dbl = {tmp, tmp} << s_data[4:0];
    rot     = rot_dbl[63:32];
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    c_d      = c_q;
    d_d      = d_q;
    msg_d    = msg_q;
    chain_d  = chain_q;
    digest_d = digest_q;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          msg_d   = msg_in;
          chain_d = chain_in;
          a_d     = chain_in[31:0];
          b_d     = chain_in[63:32];
          c_d     = chain_in[95:64];
          d_d     = chain_in[127:96];
          cnt_d   = 6'd0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        a_d = d_q;
        d_d = c_q;
        c_d = b_q;
        b_d = b_q + rot;
        if (cnt_q == 6'd63) begin
          state_d = ST_ADD;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
      ST_ADD: begin
        digest_d = {chain_q[127:96] + d_q, chain_q[95:64] + c_q,
                    chain_q[63:32]  + b_q, chain_q[31:0]  + a_q};
        done_d   = 1'b1;
        cnt_d    = 6'd0;
        state_d  = ST_IDLE;
      end
      default: begin
        cnt_d   = 6'd0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= '0;
      d_q      <= '0;
      msg_q    <= '0;
      chain_q  <= '0;
      digest_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      c_q      <= c_d;
      d_q      <= d_d;
      msg_q    <= msg_d;
      chain_q  <= chain_d;
      digest_q <= digest_d;
      done_q   <= done_d;
    end
  end

endmodule
